// File: rtl/prf_mp_rdy_pkg.sv
// Shared physical register file definitions: default sizing, tag type and
// bus-slicing helper reused by rename, ROB and issue queue.
package prf_mp_rdy_pkg;

    localparam int unsigned PRF_XLEN      = 32;
    localparam int unsigned PRF_NUM_PREG  = 64;
    localparam int unsigned PRF_NUM_RD    = 4;
    localparam int unsigned PRF_NUM_WR    = 2;
    localparam int unsigned PRF_NUM_ALLOC = 1;
    localparam int unsigned PRF_TW        = $clog2(PRF_NUM_PREG);

    typedef logic [PRF_TW-1:0] prf_tag_t;

    // Tag 0 is the hardwired zero register: reads 0, always ready.
    localparam prf_tag_t PRF_TAG_ZERO = '0;

    // Low bit index of port 'idx' inside a flattened bus of 'width'-bit fields.
    function automatic int unsigned slice_lo(int unsigned idx, int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/prf_bypass_sel.sv
// Single read-port bypass mux: compares the read tag against every write and
// alloc port and selects stored or in-flight data / ready.
module prf_bypass_sel
    import prf_mp_rdy_pkg::*;
#(
    parameter int unsigned XLEN      = PRF_XLEN,
    parameter int unsigned TW        = PRF_TW,
    parameter int unsigned NUM_WR    = PRF_NUM_WR,
    parameter int unsigned NUM_ALLOC = PRF_NUM_ALLOC
) (
    input  logic                      en,
    input  logic                      flush,
    input  logic [TW-1:0]             rd_tag,
    input  logic [XLEN-1:0]           mem_data,
    input  logic                      mem_rdy,
    input  logic [NUM_WR-1:0]         wr_en,
    input  logic [NUM_WR*TW-1:0]      wr_tag,
    input  logic [NUM_WR*XLEN-1:0]    wr_data,
    input  logic [NUM_ALLOC-1:0]      al_en,
    input  logic [NUM_ALLOC*TW-1:0]   al_tag,
    output logic [XLEN-1:0]           rd_data,
    output logic                      rd_rdy
);

    // Priority select: later write ports override earlier ones, then a
    // same-cycle alloc forces not-ready (unless flushing).
    always_comb begin
        rd_data = mem_data;
        rd_rdy  = mem_rdy;
        if (rd_tag == '0) begin
            rd_data = '0;
            rd_rdy  = 1'b1;
        end else if (en) begin
            for (int unsigned k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] && (wr_tag[slice_lo(k, TW) +: TW] == rd_tag)) begin
                    rd_data = wr_data[slice_lo(k, XLEN) +: XLEN];
                    rd_rdy  = 1'b1;
                end
            end
            if (!flush) begin
                for (int unsigned j = 0; j < NUM_ALLOC; j++) begin
                    if (al_en[j] && (al_tag[slice_lo(j, TW) +: TW] == rd_tag)) begin
                        rd_rdy = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/prf_mp_rdy.sv
// Multi-port physical register file with per-entry ready bits. Rename clears
// ready on allocation, writeback sets it; reads are combinational with
// same-cycle bypass of writes and allocations.
module prf_mp_rdy
    import prf_mp_rdy_pkg::*;
#(
    parameter int unsigned XLEN      = PRF_XLEN,
    parameter int unsigned NUM_PREG  = PRF_NUM_PREG,
    parameter int unsigned NUM_RD    = PRF_NUM_RD,
    parameter int unsigned NUM_WR    = PRF_NUM_WR,
    parameter int unsigned NUM_ALLOC = PRF_NUM_ALLOC,
    localparam int unsigned TW       = $clog2(NUM_PREG)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_WR-1:0]         wr_en,
    input  logic [NUM_WR*TW-1:0]      wr_tag,
    input  logic [NUM_WR*XLEN-1:0]    wr_data,
    input  logic [NUM_ALLOC-1:0]      al_en,
    input  logic [NUM_ALLOC*TW-1:0]   al_tag,
    input  logic [NUM_RD*TW-1:0]      rd_tag,
    output logic [NUM_RD*XLEN-1:0]    rd_data,
    output logic [NUM_RD-1:0]         rd_rdy
);

    logic [XLEN-1:0]     mem [NUM_PREG];
    logic [NUM_PREG-1:0] rdy_q;
    logic [NUM_PREG-1:0] rdy_d;

    // Ready next-state: writes set, then flush sets all or allocs clear
    // (alloc after write so alloc wins on a same-tag collision).
    always_comb begin
        rdy_d = rdy_q;
        for (int unsigned k = 0; k < NUM_WR; k++) begin
            if (wr_en[k] && (wr_tag[slice_lo(k, TW) +: TW] != '0)) begin
                rdy_d[wr_tag[slice_lo(k, TW) +: TW]] = 1'b1;
            end
        end
        if (flush) begin
            rdy_d = '1;
        end else begin
            for (int unsigned j = 0; j < NUM_ALLOC; j++) begin
                if (al_en[j] && (al_tag[slice_lo(j, TW) +: TW] != '0)) begin
                    rdy_d[al_tag[slice_lo(j, TW) +: TW]] = 1'b0;
                end
            end
        end
    end

    // Ready vector register; reset leaves every entry ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q <= '1;
        end else begin
            rdy_q <= rdy_d;
        end
    end

    // Data array; highest write port wins because its assignment comes last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_PREG; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] && (wr_tag[slice_lo(k, TW) +: TW] != '0)) begin
                    mem[wr_tag[slice_lo(k, TW) +: TW]] <= wr_data[slice_lo(k, XLEN) +: XLEN];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [TW-1:0] tag;
        assign tag = rd_tag[p*TW +: TW];

        // Bypass is disabled while reset is held so outputs show reset state.
        prf_bypass_sel #(
            .XLEN      (XLEN),
            .TW        (TW),
            .NUM_WR    (NUM_WR),
            .NUM_ALLOC (NUM_ALLOC)
        ) u_sel (
            .en       (rst),
            .flush    (flush),
            .rd_tag   (tag),
            .mem_data (mem[tag]),
            .mem_rdy  (rdy_q[tag]),
            .wr_en    (wr_en),
            .wr_tag   (wr_tag),
            .wr_data  (wr_data),
            .al_en    (al_en),
            .al_tag   (al_tag),
            .rd_data  (rd_data[p*XLEN +: XLEN]),
            .rd_rdy   (rd_rdy[p])
        );
    end

endmodule

// File: tb/tb_prf_mp_rdy.sv
// Bench for prf_mp_rdy: behavioural register-file model checked against every
// read port on each falling edge, plus directed literal expectations.
module tb_prf_mp_rdy;
    import prf_mp_rdy_pkg::*;

    localparam int XLEN = PRF_XLEN;
    localparam int NPR  = PRF_NUM_PREG;
    localparam int NRD  = PRF_NUM_RD;
    localparam int NWR  = PRF_NUM_WR;
    localparam int NAL  = PRF_NUM_ALLOC;
    localparam int TW   = PRF_TW;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic [NWR-1:0]        wr_en;
    logic [NWR*TW-1:0]     wr_tag;
    logic [NWR*XLEN-1:0]   wr_data;
    logic [NAL-1:0]        al_en;
    logic [NAL*TW-1:0]     al_tag;
    logic [NRD*TW-1:0]     rd_tag;
    logic [NRD*XLEN-1:0]   rd_data;
    logic [NRD-1:0]        rd_rdy;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    prf_mp_rdy dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_tag  (wr_tag),
        .wr_data (wr_data),
        .al_en   (al_en),
        .al_tag  (al_tag),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .rd_rdy  (rd_rdy)
    );

    always #5 clk = ~clk;

    // Reference state: plain arrays of values and ready flags.
    logic [XLEN-1:0] m_data [NPR];
    bit              m_rdy  [NPR];

    function automatic int wtag(int k);
        return int'(wr_tag[k*TW +: TW]);
    endfunction

    function automatic int atag(int j);
        return int'(al_tag[j*TW +: TW]);
    endfunction

    // Value a reader of 'tag' must see right now.
    function automatic logic [XLEN-1:0] exp_data(int tag);
        logic [XLEN-1:0] d;
        if (tag == 0 || !rst) return '0;
        d = m_data[tag];
        for (int k = 0; k < NWR; k++)
            if (wr_en[k] && wtag(k) == tag) d = wr_data[k*XLEN +: XLEN];
        return d;
    endfunction

    function automatic bit exp_rdy(int tag);
        bit r;
        if (tag == 0 || !rst) return 1'b1;
        r = m_rdy[tag];
        for (int k = 0; k < NWR; k++)
            if (wr_en[k] && wtag(k) == tag) r = 1'b1;
        for (int j = 0; j < NAL; j++)
            if (!flush && al_en[j] && atag(j) == tag) r = 1'b0;
        return r;
    endfunction

    // Model update on each edge, following the writeback/alloc/flush rules.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NPR; i++) begin
                m_data[i] <= '0;
                m_rdy[i]  <= 1'b1;
            end
        end else begin
            if (NWR > 1 && wr_en[0] && wr_en[1] && wtag(0) == wtag(1) && wtag(0) != 0)
                $display("note: protocol violation, write ports collide on tag %0d", wtag(0));
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && wtag(k) != 0) begin
                    m_data[wtag(k)] <= wr_data[k*XLEN +: XLEN];
                    m_rdy[wtag(k)]  <= 1'b1;
                end
            end
            if (flush) begin
                for (int i = 0; i < NPR; i++) m_rdy[i] <= 1'b1;
            end else begin
                for (int j = 0; j < NAL; j++)
                    if (al_en[j] && atag(j) != 0) m_rdy[atag(j)] <= 1'b0;
            end
        end
    end

    // Compare every read port against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int p = 0; p < NRD; p++) begin
                int t;
                t = int'(rd_tag[p*TW +: TW]);
                checks++;
                if (rd_data[p*XLEN +: XLEN] !== exp_data(t)) begin
                    failures++;
                    $display("FAIL model_data port%0d tag%0d act=%h exp=%h", p, t,
                             rd_data[p*XLEN +: XLEN], exp_data(t));
                end
                checks++;
                if (rd_rdy[p] !== exp_rdy(t)) begin
                    failures++;
                    $display("FAIL model_rdy port%0d tag%0d act=%b exp=%b", p, t,
                             rd_rdy[p], exp_rdy(t));
                end
            end
        end
    end

    task automatic check(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] rdd(int p);
        return rd_data[p*XLEN +: XLEN];
    endfunction

    function automatic logic [XLEN-1:0] rdr(int p);
        return {{(XLEN-1){1'b0}}, rd_rdy[p]};
    endfunction

    task automatic idle();
        wr_en = '0;
        al_en = '0;
        flush = 1'b0;
    endtask

    task automatic set_wr(int k, int tag, logic [XLEN-1:0] d);
        wr_en[k] = 1'b1;
        wr_tag[k*TW +: TW] = tag[TW-1:0];
        wr_data[k*XLEN +: XLEN] = d;
    endtask

    task automatic set_al(int tag);
        al_en[0] = 1'b1;
        al_tag[0 +: TW] = tag[TW-1:0];
    endtask

    task automatic set_rd(int p, int tag);
        rd_tag[p*TW +: TW] = tag[TW-1:0];
    endtask

    // Inputs change just after a rising edge; literal checks just after a falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        wr_tag = '0; wr_data = '0; al_tag = '0; rd_tag = '0;
        idle();
        #1 rst = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
        chk_en = 1'b1;

        // 1: reset state, then write and asynchronous mid-run reset
        set_rd(0, 0); set_rd(1, 5); set_rd(2, 63); set_rd(3, 0);
        look();
        for (int p = 0; p < 3; p++) begin
            check($sformatf("reset_data_p%0d", p), rdd(p), 32'h0);
            check($sformatf("reset_rdy_p%0d", p), rdr(p), 32'h1);
        end
        cyc(); set_wr(0, 5, 32'hDEADBEEF); set_rd(0, 5);
        look(); check("wr5_bypass", rdd(0), 32'hDEADBEEF);
        cyc(); idle();
        look(); check("wr5_stored", rdd(0), 32'hDEADBEEF);
        #1 rst = 1'b0;
        #1 check("midrst_data", rdd(0), 32'h0);
        check("midrst_rdy", rdr(0), 32'h1);
        set_wr(0, 5, 32'h11111111); set_al(5);
        cyc(); idle(); rst = 1'b1;
        look(); check("postrst_data", rdd(0), 32'h0);
        check("postrst_rdy", rdr(0), 32'h1);

        // 2: alloc then writeback with bypass
        cyc(); set_al(7); set_rd(0, 7);
        look(); check("al7_bypass_rdy", rdr(0), 32'h0);
        cyc(); idle();
        look(); check("al7_rdy", rdr(0), 32'h0);
        cyc(); set_wr(1, 7, 32'h12345678);
        look(); check("wr7_byp_data", rdd(0), 32'h12345678);
        check("wr7_byp_rdy", rdr(0), 32'h1);
        cyc(); idle();
        look(); check("wr7_data", rdd(0), 32'h12345678);
        check("wr7_rdy", rdr(0), 32'h1);

        // 3: tag 0 is immutable
        cyc(); set_wr(0, 0, 32'hFFFFFFFF); set_al(0); set_rd(0, 0);
        look(); check("t0_same_data", rdd(0), 32'h0);
        check("t0_same_rdy", rdr(0), 32'h1);
        cyc(); idle();
        look(); check("t0_next_data", rdd(0), 32'h0);
        check("t0_next_rdy", rdr(0), 32'h1);

        // 4: write-port collision, highest port wins
        cyc(); set_wr(0, 9, 32'hA); set_wr(1, 9, 32'hB); set_rd(0, 9);
        look(); check("t9_bypass", rdd(0), 32'hB);
        cyc(); idle();
        look(); check("t9_stored", rdd(0), 32'hB);

        // 5: alloc and write on same tag, alloc wins ready
        cyc(); set_al(12); set_wr(0, 12, 32'h55); set_rd(0, 12);
        look(); check("t12_same_data", rdd(0), 32'h55);
        check("t12_same_rdy", rdr(0), 32'h0);
        cyc(); idle();
        look(); check("t12_next_data", rdd(0), 32'h55);
        check("t12_next_rdy", rdr(0), 32'h0);

        // 6: allocs then flush with a simultaneous alloc
        cyc(); set_wr(0, 3, 32'h33); set_wr(1, 4, 32'h44);
        cyc(); idle(); set_al(3);
        cyc(); idle(); set_al(4);
        cyc(); idle(); set_al(5);
        set_rd(0, 3); set_rd(1, 4); set_rd(2, 5); set_rd(3, 6);
        look(); check("pre_flush_rdy3", rdr(0), 32'h0);
        check("pre_flush_rdy4", rdr(1), 32'h0);
        cyc(); idle(); flush = 1'b1; set_al(6);
        look(); check("flush_al6_rdy", rdr(3), 32'h1);
        cyc(); idle();
        look();
        for (int p = 0; p < 4; p++)
            check($sformatf("post_flush_rdy_p%0d", p), rdr(p), 32'h1);
        check("post_flush_d3", rdd(0), 32'h33);
        check("post_flush_d4", rdd(1), 32'h44);
        check("post_flush_d5", rdd(2), 32'h0);
        check("post_flush_d6", rdd(3), 32'h0);

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prf_mp_rdy.md
Name: prf_mp_rdy

Overview:
Parametrised multi-port physical register file for the OoO core. It holds NUM_PREG entries of XLEN bits, with NUM_RD read ports and NUM_WR writeback ports. Each entry carries a ready bit: rename clears it on allocation, writeback sets it. Sits between rename/issue (reads, ready polls) and the CDB writeback path, and replaces the single-write architectural RF.

Parameters:
XLEN, 32, data width per entry
NUM_PREG, 64, number of physical registers (power of 2, >=32)
NUM_RD, 4, read ports (operand fetch plus ready poll)
NUM_WR, 2, writeback ports
NUM_ALLOC, 1, allocation (ready-clear) ports
TW, $clog2(NUM_PREG), tag width (derived localparam)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-low
flush  input  1  pipeline flush; sets all ready bits
wr_en  input  NUM_WR  per-port write enable
wr_tag  input  NUM_WR*TW  write tags, port k at [k*TW +: TW]
wr_data  input  NUM_WR*XLEN  write data, port k at [k*XLEN +: XLEN]
al_en  input  NUM_ALLOC  allocation enable
al_tag  input  NUM_ALLOC*TW  tags being allocated (ready cleared)
rd_tag  input  NUM_RD*TW  read tags
rd_data  output  NUM_RD*XLEN  read data
rd_rdy  output  NUM_RD  ready bit of the read tag

Behaviour:
- Reset (rst=0, async): all data=0, all ready=1. rd_data/rd_rdy then reflect the reset state combinationally: 0 and 1.
- Tag 0 is hardwired: data always 0, ready always 1. Writes and allocations to tag 0 are ignored and not bypassed.
- Write: on rising edge, for each k with wr_en[k]=1 and wr_tag!=0: mem[tag] <= data and rdy[tag] <= 1.
- Write conflict (two ports, same tag, same cycle): highest port index wins. The bench flags this as a protocol violation but the RTL must stay deterministic.
- Allocate: on rising edge, for each al_en[j]=1 and al_tag!=0: rdy[tag] <= 0. Data is unchanged.
- Alloc and write to the same tag in the same cycle: alloc wins, so ready=0. The data is still written.
- Flush: on rising edge with flush=1, all ready bits <= 1 and allocations that cycle are ignored. Writes that cycle still update data. Data is otherwise preserved.
- Reads: combinational, zero latency. Bypass: if any wr_en[k] matches rd_tag (nonzero) in the same cycle, rd_data = that wr_data (highest k wins) and rd_rdy = 1, unless a same-cycle alloc targets that tag.
- Ready bypass for alloc: if al_en[j] matches rd_tag in the same cycle and flush=0, rd_rdy = 0. Alloc has priority over write bypass for rd_rdy.
- Reset asserted mid-operation: state clears immediately and all pending enables are ignored until rst=1.
- No internal counters wrap. Tags >= NUM_PREG are impossible by construction.

Decomposition:
- Shared package/include (prf_defs): XLEN, NUM_PREG, TW, the tag-0 constant, and port-slice helper macros. It is reused by rename, ROB and the issue queue.
- One sub-module is natural: prf_bypass_sel. It is a single read-port bypass mux (tag compare against all write and alloc ports, priority select) and is instantiated NUM_RD times.
- The storage array and ready vector stay in the top module.

Test Plan:
1. Reset then read tags 0, 5, 63 -> rd_data=0, rd_rdy=1 on all ports. Pulse rst low mid-run after writing tag 5 = 0xDEADBEEF -> tag 5 reads 0.
2. Alloc tag 7, next cycle read 7 -> rdy=0. Write 7 = 0x12345678 on port 1, same cycle read 7 -> rd_data=0x12345678, rdy=1 (bypass). Next cycle still 0x12345678, rdy=1.
3. Write tag 0 = 0xFFFFFFFF and alloc tag 0 -> tag 0 reads 0, rdy=1 in the same and following cycle.
4. Ports 0 and 1 both write tag 9 (0xA, 0xB) -> same-cycle read gives 0xB. After the edge, mem[9]=0xB.
5. Alloc tag 12 and write tag 12 = 0x55 in the same cycle -> rd_rdy=0 that cycle and after. Data reads 0x55.
6. Alloc tags 3, 4, 5 over successive cycles, then flush together with alloc of tag 6 -> after the edge, tags 3–6 all rdy=1 and data is unchanged.
